id_exe_pipe_reg: RTL
====================

Name: id_exe_pipe_reg

Overview:
- Pipeline register between the ID stage and the EXE stage of the ARM core.
- Captures decoded control, operand values, shift operand and destination information each cycle, and presents them to EXE (ALU, Val2 generation, branch target adder).
- Implements hold (memory wait), flush (taken branch) and bubble insertion (data hazard), plus a saturating bubble counter for performance analysis.

Parameters:
- DATA_W, 32, width of PC and register operand values.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  freeze all contents (memory stall)
- flush  in  1  squash incoming instruction (branch taken in EXE)
- bubble  in  1  insert NOP (hazard detected in ID)
- valid_in  in  1  ID holds a real instruction
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  decoded control bits
- EXE_CMD_in  in  4  ALU command
- PC_in  in  DATA_W  PC+4 of the instruction
- Val_Rn_in, Val_Rm_in  in  DATA_W  register file read values
- Imm_in  in  1  I bit of the data-processing encoding
- Shift_operand_in  in  12  instr[11:0]
- Signed_imm_24_in  in  24  branch offset
- Dest_in, Src1_in, Src2_in  in  4 each  register indices
- SR_in  in  4  status flags N,Z,C,V at issue
- valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out  out  1 each  registered copies
- EXE_CMD_out  out  4
- PC_out, Val_Rn_out, Val_Rm_out  out  DATA_W
- Imm_out  out  1
- Shift_operand_out  out  12
- Signed_imm_24_out  out  24
- Dest_out, Src1_out, Src2_out  out  4
- SR_out  out  4
- Val2_Src_out  out  1  registered (MEM_R_EN_in | MEM_W_EN_in); selects the memory-offset path in Val2 generation
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, including bubble_cnt. Contents return to 0 immediately on assertion, mid-operation included, with no dependence on clk.
- One update per rising clk. Priority order: hold > flush > bubble > load.
- hold=1: all outputs and bubble_cnt keep their values. A flush or bubble asserted in the same cycle is ignored; upstream logic re-asserts it after hold drops.
- flush=1 (hold=0): squash the incoming instruction.
  - Cleared: valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S, Val2_Src.
  - Zeroed: EXE_CMD, Dest, Src1, Src2.
  - Data fields (PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, Imm, SR) also load 0.
  - bubble_cnt increments.
- bubble=1 (hold=0, flush=0): identical clearing to flush; bubble_cnt increments.
- Load (all three control inputs 0): every output takes its _in value on the next edge. valid_out=valid_in. Latency is exactly one cycle.
- valid_in=0 on a load: fields load normally; bubble_cnt is unchanged. Only flush and bubble are counted.
- bubble_cnt saturates at 2^CNT_W-1 and never wraps.
- flush and bubble together count once per cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive all inputs to nonzero values, pulse rst_n low between edges -> all outputs read 0 before the next clk edge; bubble_cnt=0.
- Load: valid_in=1, WB_EN_in=1, EXE_CMD_in=4'b0010, Val_Rm_in=32'hDEADBEEF, Shift_operand_in=12'h0A3, Dest_in=4'd5 -> one edge later outputs match exactly; Val2_Src_out=0. Repeat with MEM_R_EN_in=1 -> Val2_Src_out=1.
- Hold: load PC_in=32'h100, then hold=1 for 3 cycles while PC_in=32'h104, 32'h108, 32'h10C -> PC_out stays 32'h100; with flush=1 during hold, bubble_cnt does not change.
- Flush vs bubble: flush=1 and bubble=1 with WB_EN_in=1, Dest_in=4'd7 -> valid_out=0, WB_EN_out=0, Dest_out=0; bubble_cnt increments by exactly 1.
- Saturation: CNT_W=4, assert bubble for 20 cycles -> bubble_cnt reaches 15 and stays 15.
- Back-to-back: sequence load A, bubble, load B, flush, load C -> valid_out sequence 1,0,1,0,1 on consecutive edges; bubble_cnt=2.

Source files
------------

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: captures decoded control and operands for EXE, with hold,
// flush and bubble handling plus a saturating counter of inserted bubbles.
module id_exe_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              Imm_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        Src1_in,
  input  logic [3:0]        Src2_in,
  input  logic [3:0]        SR_in,
  output logic              valid_out,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic              B_out,
  output logic              S_out,
  output logic [3:0]        EXE_CMD_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] Val_Rn_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic              Imm_out,
  output logic [11:0]       Shift_operand_out,
  output logic [23:0]       Signed_imm_24_out,
  output logic [3:0]        Dest_out,
  output logic [3:0]        Src1_out,
  output logic [3:0]        Src2_out,
  output logic [3:0]        SR_out,
  output logic              Val2_Src_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        sr;
    logic              val2_src;
  } pipe_t;

  pipe_t            pipe_in, pipe_d, pipe_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             squash;

  assign squash = flush | bubble;

  always_comb begin
    pipe_in               = '0;
    pipe_in.valid         = valid_in;
    pipe_in.wb_en         = WB_EN_in;
    pipe_in.mem_r_en      = MEM_R_EN_in;
    pipe_in.mem_w_en      = MEM_W_EN_in;
    pipe_in.b             = B_in;
    pipe_in.s             = S_in;
    pipe_in.exe_cmd       = EXE_CMD_in;
    pipe_in.pc            = PC_in;
    pipe_in.val_rn        = Val_Rn_in;
    pipe_in.val_rm        = Val_Rm_in;
    pipe_in.imm           = Imm_in;
    pipe_in.shift_operand = Shift_operand_in;
    pipe_in.signed_imm_24 = Signed_imm_24_in;
    pipe_in.dest          = Dest_in;
    pipe_in.src1          = Src1_in;
    pipe_in.src2          = Src2_in;
    pipe_in.sr            = SR_in;
    // Loads and stores take the memory-offset path in Val2 generation.
    pipe_in.val2_src      = MEM_R_EN_in | MEM_W_EN_in;
  end

  always_comb begin
    pipe_d = pipe_q;
    cnt_d  = cnt_q;
    if (!hold) begin
      pipe_d = squash ? '0 : pipe_in;
      if (squash && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_out         = pipe_q.valid;
  assign WB_EN_out         = pipe_q.wb_en;
  assign MEM_R_EN_out      = pipe_q.mem_r_en;
  assign MEM_W_EN_out      = pipe_q.mem_w_en;
  assign B_out             = pipe_q.b;
  assign S_out             = pipe_q.s;
  assign EXE_CMD_out       = pipe_q.exe_cmd;
  assign PC_out            = pipe_q.pc;
  assign Val_Rn_out        = pipe_q.val_rn;
  assign Val_Rm_out        = pipe_q.val_rm;
  assign Imm_out           = pipe_q.imm;
  assign Shift_operand_out = pipe_q.shift_operand;
  assign Signed_imm_24_out = pipe_q.signed_imm_24;
  assign Dest_out          = pipe_q.dest;
  assign Src1_out          = pipe_q.src1;
  assign Src2_out          = pipe_q.src2;
  assign SR_out            = pipe_q.sr;
  assign Val2_Src_out      = pipe_q.val2_src;
  assign bubble_cnt        = cnt_q;

endmodule
